serial_to_parallel_converter: RTL

Receive-side counterpart of the team's parallel-to-serial converter. Accepts one serial bit per accepted cycle, assembles N-bit words in either MSB-first or LSB-first order, and presents each completed word on a registered output with a valid/ready handshake. One-word output buffering lets the next word fill while the previous one waits to be consumed.

---
 rtl/serial_to_parallel_converter_pkg.sv | 10 +
 rtl/serial_to_parallel_converter.sv | 99 +++++++++
 2 files changed

// File: rtl/serial_to_parallel_converter_pkg.sv
// Types shared between the transmit- and receive-side serial converters.
package serial_to_parallel_converter_pkg;

  // Bit order on the serial line.
  typedef enum logic [0:0] {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } shift_direction_t_;

endpackage : serial_to_parallel_converter_pkg

// File: rtl/serial_to_parallel_converter.sv
// Serial-to-parallel converter: assembles N-bit words from a serial bit
// stream (MSB- or LSB-first) and holds each finished word in a one-deep
// valid/ready output register while the next word keeps filling.
module serial_to_parallel_converter
  import serial_to_parallel_converter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_bit,
  input  shift_direction_t_      direction,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [N-1:0]           o_data,
  output logic [N-1:0]           q,
  output logic [$clog2(N)-1:0]   count
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-1:0]      q_q, q_d;
  logic [CW-1:0]     count_q, count_d;
  shift_direction_t_ dir_q, dir_d;
  logic [N-1:0]      o_data_q, o_data_d;
  logic              o_valid_q, o_valid_d;

  logic              accept;
  logic              last_bit;
  shift_direction_t_ eff_dir;
  logic [N-1:0]      shifted;

  // Handshake, shift value and next state. The first bit of a word uses the
  // live direction input; later bits follow the direction latched with it.
  // Only the completing bit can stall, and only while the previous word is
  // still unconsumed. i_ready reads 1 throughout reset.
  always_comb begin
    last_bit  = (count_q == LAST);
    i_ready   = !rst || !(o_valid_q && !o_ready && last_bit);
    accept    = i_valid && i_ready;
    eff_dir   = (count_q == '0) ? direction : dir_q;
    shifted   = (eff_dir == MSB_FIRST) ? {q_q[N-2:0], i_bit}
                                       : {i_bit, q_q[N-1:1]};
    q_d       = q_q;
    count_d   = count_q;
    dir_d     = dir_q;
    o_data_d  = o_data_q;
    o_valid_d = o_valid_q;
    if (accept) begin
      if (count_q == '0) dir_d = direction;
      if (last_bit) begin
        q_d     = '0;
        count_d = '0;
      end else begin
        q_d     = shifted;
        count_d = count_q + CW'(1);
      end
    end
    if (accept && last_bit) begin
      o_data_d  = shifted;
      o_valid_d = 1'b1;
    end else if (o_valid_q && o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // Word assembly state: shift register, bit count and latched direction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q     <= '0;
      count_q <= '0;
      dir_q   <= MSB_FIRST;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  // Output word register with its valid flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign q       = q_q;
  assign count   = count_q;
  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

endmodule : serial_to_parallel_converter
